ir_cmd_controller: RTL and testbench
====================================

// Module: ir_cmd_controller
// PURPOSE
//   Sequences decoded frames from the infrared receiver into actuator outputs w1..w4.
//   Validates each 32-bit frame (address match plus complement checks) and maps the command byte to one output.
//   Holds that output while repeat codes arrive and releases it on timeout or STOP.
//   Sits between the infrared decoder and the board actuators; exposes estado for debug.
// PARAMETERS
//   ADDR         8'h00   accepted device address
//   HOLD_CYCLES  1000    clk cycles an output stays on after the last frame or repeat (>=2)
//   CMD_W1       8'h18   command code driving w1
//   CMD_W2       8'h52   command code driving w2
//   CMD_W3       8'h08   command code driving w3
//   CMD_W4       8'h5A   command code driving w4
//   CMD_STOP     8'h1C   command code clearing all outputs
//   ERR_W        8       error counter width
// PORTS
//   clk          in   1      system clock, rising edge
//   reset        in   1      asynchronous, active-high reset
//   frame_valid  in   1      1-cycle pulse, frame_data valid
//   frame_data   in   32     [7:0] addr, [15:8] ~addr, [23:16] cmd, [31:24] ~cmd
//   repeat_pulse in   1      1-cycle pulse, decoder saw a repeat code
//   w1..w4       out  1 each actuator outputs, at most one high
//   cmd_valid    out  1      1-cycle pulse, a frame passed validation
//   cmd_code     out  8      last validated command, held
//   err_count    out  ERR_W  rejected plus dropped frames, saturating
//   estado       out  3      FSM state
// BEHAVIOUR
//   Reset: all outputs 0, estado=IDLE, pending slot empty, timer 0.
//   States: IDLE=0, CHECK=1, DRIVE=2, HOLD=3.
//   - IDLE/HOLD: frame_valid at edge t loads frame_q and enters CHECK.
//   - CHECK: exactly 1 cycle. Frame is valid iff addr==ADDR, addr^~addr==8'hFF and cmd^~cmd==8'hFF.
//   - Valid frame at edge t+1:
//       cmd_valid=1 for one cycle; cmd_code=cmd.
//       CMD_Wn: the one-hot output is set (others cleared) and the FSM enters DRIVE.
//       CMD_STOP: all w cleared and the FSM enters IDLE.
//       Other codes: w unchanged; FSM enters HOLD if any w is high, else IDLE; the timer is not reloaded.
//   - Invalid frame: err_count+1 (saturates at all-ones); w unchanged; FSM enters HOLD if any w is high, else IDLE.
//   - DRIVE: 1 cycle; loads timer=HOLD_CYCLES-1, then enters HOLD.
//   - Latency: frame_valid at edge t gives w and cmd_valid at edge t+1.
//   - HOLD: timer decrements each cycle. repeat_pulse reloads HOLD_CYCLES-1. At timer==0: all w cleared, enter IDLE.
//   - repeat_pulse in IDLE, CHECK or DRIVE: ignored.
//   - frame_valid during CHECK or DRIVE: stored in a 1-deep pending slot and consumed on the next IDLE/HOLD cycle as if it had just arrived.
//       A second arrival while the slot is full overwrites it and increments err_count.
//   - Simultaneous frame_valid and timer==0 in HOLD: w cleared and frame enters CHECK; timer expiry does not also enter IDLE.
//   - Simultaneous frame_valid and repeat_pulse in HOLD: frame wins; the repeat is dropped.
//   - Async reset mid-operation: everything returns to reset values immediately; the pending frame is discarded.
// STRUCTURE
//   ir_pkg (shared): state encodings, frame field offsets/widths, STOP/CMD defaults.
//   Sub-module ir_hold_timer:
//       inputs load, reload, enable; output expired;
//       down counter of width $clog2(HOLD_CYCLES).
//   FSM, validation compare, pending slot and output regs stay in this module.
// TESTING (HOLD_CYCLES=16 in sim)
//   1. frame 32'hE718FF00 -> after 1 clk cmd_valid pulse, cmd_code=8'h18, w1=1; with no repeats w1 drops 16 clks after DRIVE; estado 1->2->3->0.
//   2. w1 active; repeat_pulse every 10 clks x3 -> w1 stays high; drops 16 clks after the last repeat.
//   3. Bad complement 32'hE719FF00, then wrong address 32'hE718FE01 -> no cmd_valid, w unchanged, err_count=2.
//   4. w2 active; STOP frame 32'hE31CFF00 -> all w=0 and estado=IDLE one clk after CHECK.
//   5. Three frames on consecutive clks (W1, W3, W4) -> W1 processed; W3 overwritten by W4 (err_count+1); final output w4 only.
//   6. reset pulse while in HOLD with w3=1 -> w3=0, estado=0 asynchronously; a later repeat_pulse has no effect.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared types and defaults for the infrared command controller: FSM state
// encodings, the 32-bit NEC-style frame layout and default command codes.
package ir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_DRIVE = 3'd2,
    ST_HOLD  = 3'd3
  } state_e;

  localparam int FIELD_W = 8;

  // Packed so that addr lands on [7:0] and ncmd on [31:24] of the raw frame.
  typedef struct packed {
    logic [FIELD_W-1:0] ncmd;
    logic [FIELD_W-1:0] cmd;
    logic [FIELD_W-1:0] naddr;
    logic [FIELD_W-1:0] addr;
  } frame_t;

  localparam logic [FIELD_W-1:0] DEF_ADDR     = 8'h00;
  localparam logic [FIELD_W-1:0] DEF_CMD_W1   = 8'h18;
  localparam logic [FIELD_W-1:0] DEF_CMD_W2   = 8'h52;
  localparam logic [FIELD_W-1:0] DEF_CMD_W3   = 8'h08;
  localparam logic [FIELD_W-1:0] DEF_CMD_W4   = 8'h5A;
  localparam logic [FIELD_W-1:0] DEF_CMD_STOP = 8'h1C;

  function automatic logic frame_ok(input frame_t f, input logic [FIELD_W-1:0] dev_addr);
    return (f.addr == dev_addr) &&
           ((f.addr ^ f.naddr) == 8'hFF) &&
           ((f.cmd ^ f.ncmd) == 8'hFF);
  endfunction

endpackage

// File: rtl/ir_hold_timer.sv
// Down counter that measures how long an actuator output stays on after the
// last accepted frame or repeat code; it parks at zero instead of wrapping.
module ir_hold_timer #(
  parameter int HOLD_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic reload,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] START_VAL = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (load || reload) begin
      r_count <= START_VAL;
    end else if (enable && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign expired = (r_count == '0);

endmodule

// File: rtl/ir_cmd_controller.sv
// Turns validated IR frames into one-hot actuator outputs w1..w4, holds the
// output while repeat codes arrive and drops it on timeout or a STOP command.
module ir_cmd_controller
  import ir_pkg::*;
#(
  parameter logic [7:0] ADDR        = DEF_ADDR,
  parameter int         HOLD_CYCLES = 1000,
  parameter logic [7:0] CMD_W1      = DEF_CMD_W1,
  parameter logic [7:0] CMD_W2      = DEF_CMD_W2,
  parameter logic [7:0] CMD_W3      = DEF_CMD_W3,
  parameter logic [7:0] CMD_W4      = DEF_CMD_W4,
  parameter logic [7:0] CMD_STOP    = DEF_CMD_STOP,
  parameter int         ERR_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_valid,
  input  logic [31:0]      frame_data,
  input  logic             repeat_pulse,
  output logic             w1,
  output logic             w2,
  output logic             w3,
  output logic             w4,
  output logic             cmd_valid,
  output logic [7:0]       cmd_code,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       estado
);

  state_e           r_state, w_state_nxt;
  frame_t           r_frame_q, w_frame_q_nxt;
  frame_t           r_pend_data, w_pend_data_nxt;
  logic             r_pend_valid, w_pend_valid_nxt;
  logic [3:0]       r_w, w_w_nxt;
  logic             r_cmd_valid, w_cmd_valid_nxt;
  logic [7:0]       r_cmd_code, w_cmd_code_nxt;
  logic [ERR_W-1:0] r_err;
  logic [ERR_W:0]   w_err_sum;

  frame_t w_incoming;
  logic   w_accept, w_take_pend, w_start, w_frame_ok, w_any;
  logic   w_reject, w_overflow;
  logic   w_tmr_load, w_tmr_reload, w_tmr_enable, w_tmr_expired;

  assign w_incoming  = frame_t'(frame_data);
  assign w_accept    = (r_state == ST_IDLE) || (r_state == ST_HOLD);
  assign w_take_pend = w_accept && r_pend_valid;
  assign w_start     = w_take_pend || (w_accept && frame_valid);
  assign w_frame_ok  = frame_ok(r_frame_q, ADDR);
  assign w_any       = |r_w;

  ir_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (w_tmr_load),
    .reload (w_tmr_reload),
    .enable (w_tmr_enable),
    .expired(w_tmr_expired)
  );

  // A pending frame is always consumed first; a frame arriving in that same
  // cycle refills the slot it just vacated.
  always_comb begin
    w_pend_valid_nxt = r_pend_valid;
    w_pend_data_nxt  = r_pend_data;
    w_overflow       = 1'b0;
    if (w_take_pend) begin
      w_pend_valid_nxt = frame_valid;
      w_pend_data_nxt  = w_incoming;
    end else if (!w_accept && frame_valid) begin
      w_pend_valid_nxt = 1'b1;
      w_pend_data_nxt  = w_incoming;
      w_overflow       = r_pend_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_frame_q_nxt   = r_frame_q;
    w_w_nxt         = r_w;
    w_cmd_valid_nxt = 1'b0;
    w_cmd_code_nxt  = r_cmd_code;
    w_reject        = 1'b0;
    w_tmr_load      = 1'b0;
    w_tmr_reload    = 1'b0;
    w_tmr_enable    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_frame_q_nxt = w_take_pend ? r_pend_data : w_incoming;
          w_state_nxt   = ST_CHECK;
        end
      end
      ST_HOLD: begin
        w_tmr_enable = 1'b1;
        if (w_start) begin
          w_frame_q_nxt = w_take_pend ? r_pend_data : w_incoming;
          w_state_nxt   = ST_CHECK;
          if (w_tmr_expired) w_w_nxt = '0;
        end else if (repeat_pulse) begin
          w_tmr_reload = 1'b1;
        end else if (w_tmr_expired) begin
          w_w_nxt     = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CHECK: begin
        w_state_nxt = w_any ? ST_HOLD : ST_IDLE;
        if (w_frame_ok) begin
          w_cmd_valid_nxt = 1'b1;
          w_cmd_code_nxt  = r_frame_q.cmd;
          if (r_frame_q.cmd == CMD_W1) begin
            w_w_nxt = 4'b0001; w_state_nxt = ST_DRIVE;
          end else if (r_frame_q.cmd == CMD_W2) begin
            w_w_nxt = 4'b0010; w_state_nxt = ST_DRIVE;
          end else if (r_frame_q.cmd == CMD_W3) begin
            w_w_nxt = 4'b0100; w_state_nxt = ST_DRIVE;
          end else if (r_frame_q.cmd == CMD_W4) begin
            w_w_nxt = 4'b1000; w_state_nxt = ST_DRIVE;
          end else if (r_frame_q.cmd == CMD_STOP) begin
            w_w_nxt = '0; w_state_nxt = ST_IDLE;
          end
        end else begin
          w_reject = 1'b1;
        end
      end
      ST_DRIVE: begin
        w_tmr_load  = 1'b1;
        w_state_nxt = ST_HOLD;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Rejection and slot overflow can coincide, so the counter may step by two.
  assign w_err_sum = {1'b0, r_err} + (ERR_W+1)'(w_reject) + (ERR_W+1)'(w_overflow);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_q    <= '0;
      r_pend_data  <= '0;
      r_pend_valid <= 1'b0;
      r_w          <= '0;
      r_cmd_valid  <= 1'b0;
      r_cmd_code   <= '0;
      r_err        <= '0;
    end else begin
      r_frame_q    <= w_frame_q_nxt;
      r_pend_data  <= w_pend_data_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_w          <= w_w_nxt;
      r_cmd_valid  <= w_cmd_valid_nxt;
      r_cmd_code   <= w_cmd_code_nxt;
      r_err        <= w_err_sum[ERR_W] ? '1 : w_err_sum[ERR_W-1:0];
    end
  end

  assign w1        = r_w[0];
  assign w2        = r_w[1];
  assign w3        = r_w[2];
  assign w4        = r_w[3];
  assign cmd_valid = r_cmd_valid;
  assign cmd_code  = r_cmd_code;
  assign err_count = r_err;
  assign estado    = r_state;

endmodule

// File: tb/tb_ir_cmd_controller.sv
// Directed bench for ir_cmd_controller with a 16-cycle hold time; each task
// drives one scenario and compares outputs against hand-computed values.
module tb_ir_cmd_controller;

  localparam int HOLD = 16;

  localparam logic [31:0] F_W1       = 32'hE718FF00;
  localparam logic [31:0] F_W2       = 32'hAD52FF00;
  localparam logic [31:0] F_W3       = 32'hF708FF00;
  localparam logic [31:0] F_W4       = 32'hA55AFF00;
  localparam logic [31:0] F_STOP     = 32'hE31CFF00;
  localparam logic [31:0] F_OTHER    = 32'hBB44FF00;
  localparam logic [31:0] F_BAD_CMP  = 32'hE719FF00;
  localparam logic [31:0] F_BAD_ADDR = 32'hE718FE01;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_valid;
  logic [31:0] frame_data;
  logic        repeat_pulse;
  logic        w1, w2, w3, w4;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic [7:0]  err_count;
  logic [2:0]  estado;
  logic [3:0]  w_vec;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign w_vec = {w4, w3, w2, w1};

  ir_cmd_controller #(.HOLD_CYCLES(HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .repeat_pulse(repeat_pulse),
    .w1          (w1),
    .w2          (w2),
    .w3          (w3),
    .w4          (w4),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .err_count   (err_count),
    .estado      (estado)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] d);
    frame_valid = 1'b1;
    frame_data  = d;
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_valid = 1'b0; frame_data = '0; repeat_pulse = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (w_vec !== 4'b0000) begin tests_failed++; $display("FAIL reset_w: got %b expected 0000", w_vec); end
    tests_run++;
    if (estado !== 3'd0) begin tests_failed++; $display("FAIL reset_estado: got %0d expected 0", estado); end
    tests_run++;
    if ({cmd_valid, cmd_code, err_count} !== 17'd0) begin
      tests_failed++; $display("FAIL reset_regs: cmd_valid=%b cmd_code=%h err=%0d expected all 0", cmd_valid, cmd_code, err_count);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_w1_timeout();
    int n;
    send_frame(F_W1);
    tests_run++;
    if (estado !== 3'd1) begin tests_failed++; $display("FAIL w1_check_state: got %0d expected 1", estado); end
    tick();
    tests_run++;
    if (cmd_valid !== 1'b1 || cmd_code !== 8'h18) begin
      tests_failed++; $display("FAIL w1_cmd: cmd_valid=%b cmd_code=%h expected 1/18", cmd_valid, cmd_code);
    end
    tests_run++;
    if (w_vec !== 4'b0001 || estado !== 3'd2) begin
      tests_failed++; $display("FAIL w1_drive: w=%b estado=%0d expected 0001/2", w_vec, estado);
    end
    tick();
    tests_run++;
    if (estado !== 3'd3 || cmd_valid !== 1'b0) begin
      tests_failed++; $display("FAIL w1_hold: estado=%0d cmd_valid=%b expected 3/0", estado, cmd_valid);
    end
    n = 0;
    while (w1 === 1'b1 && n < 40) begin tick(); n++; end
    tests_run++;
    if (n !== HOLD) begin tests_failed++; $display("FAIL w1_hold_len: got %0d cycles expected %0d", n, HOLD); end
    tests_run++;
    if (estado !== 3'd0) begin tests_failed++; $display("FAIL w1_idle: got %0d expected 0", estado); end
  endtask

  task automatic test_repeat();
    int n;
    send_frame(F_W1);
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      repeat (9) tick();
      repeat_pulse = 1'b1;
      tick();
      repeat_pulse = 1'b0;
    end
    tests_run++;
    if (w1 !== 1'b1 || estado !== 3'd3) begin
      tests_failed++; $display("FAIL rep_held: w1=%b estado=%0d expected 1/3", w1, estado);
    end
    n = 0;
    while (w1 === 1'b1 && n < 40) begin tick(); n++; end
    tests_run++;
    if (n !== HOLD) begin tests_failed++; $display("FAIL rep_hold_len: got %0d cycles expected %0d", n, HOLD); end
  endtask

  task automatic test_expiry_frame();
    send_frame(F_W1);
    tick();
    tick();
    repeat (15) tick();
    send_frame(F_OTHER);
    tests_run++;
    if (w_vec !== 4'b0000 || estado !== 3'd1) begin
      tests_failed++; $display("FAIL exp_frame: w=%b estado=%0d expected 0000/1", w_vec, estado);
    end
    tick();
    tests_run++;
    if (cmd_valid !== 1'b1 || cmd_code !== 8'h44 || estado !== 3'd0) begin
      tests_failed++; $display("FAIL exp_other: cmd_valid=%b cmd_code=%h estado=%0d expected 1/44/0", cmd_valid, cmd_code, estado);
    end
  endtask

  task automatic test_errors();
    send_frame(F_BAD_CMP);
    tick();
    tests_run++;
    if (cmd_valid !== 1'b0 || err_count !== 8'd1 || estado !== 3'd0) begin
      tests_failed++; $display("FAIL err_cmp: cmd_valid=%b err=%0d estado=%0d expected 0/1/0", cmd_valid, err_count, estado);
    end
    send_frame(F_BAD_ADDR);
    tick();
    tests_run++;
    if (cmd_valid !== 1'b0 || err_count !== 8'd2) begin
      tests_failed++; $display("FAIL err_addr: cmd_valid=%b err=%0d expected 0/2", cmd_valid, err_count);
    end
    tests_run++;
    if (cmd_code !== 8'h44 || w_vec !== 4'b0000) begin
      tests_failed++; $display("FAIL err_keep: cmd_code=%h w=%b expected 44/0000", cmd_code, w_vec);
    end
  endtask

  task automatic test_stop();
    send_frame(F_W2);
    tick();
    tests_run++;
    if (w_vec !== 4'b0010) begin tests_failed++; $display("FAIL stop_w2: got %b expected 0010", w_vec); end
    tick();
    send_frame(F_BAD_CMP);
    tick();
    tests_run++;
    if (err_count !== 8'd3 || w_vec !== 4'b0010 || estado !== 3'd3) begin
      tests_failed++; $display("FAIL stop_bad_in_hold: err=%0d w=%b estado=%0d expected 3/0010/3", err_count, w_vec, estado);
    end
    send_frame(F_STOP);
    tick();
    tests_run++;
    if (w_vec !== 4'b0000 || estado !== 3'd0) begin
      tests_failed++; $display("FAIL stop_clear: w=%b estado=%0d expected 0000/0", w_vec, estado);
    end
    tests_run++;
    if (cmd_valid !== 1'b1 || cmd_code !== 8'h1C) begin
      tests_failed++; $display("FAIL stop_cmd: cmd_valid=%b cmd_code=%h expected 1/1c", cmd_valid, cmd_code);
    end
  endtask

  task automatic test_back_to_back();
    frame_valid = 1'b1;
    frame_data  = F_W1;
    tick();
    frame_data  = F_W3;
    tick();
    tests_run++;
    if (w_vec !== 4'b0001 || cmd_code !== 8'h18 || estado !== 3'd2) begin
      tests_failed++; $display("FAIL b2b_first: w=%b cmd_code=%h estado=%0d expected 0001/18/2", w_vec, cmd_code, estado);
    end
    frame_data  = F_W4;
    tick();
    frame_valid = 1'b0;
    tests_run++;
    if (err_count !== 8'd4 || estado !== 3'd3) begin
      tests_failed++; $display("FAIL b2b_overwrite: err=%0d estado=%0d expected 4/3", err_count, estado);
    end
    tick();
    tests_run++;
    if (estado !== 3'd1 || cmd_valid !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_pending: estado=%0d cmd_valid=%b expected 1/0", estado, cmd_valid);
    end
    tick();
    tests_run++;
    if (w_vec !== 4'b1000 || cmd_code !== 8'h5A || cmd_valid !== 1'b1 || estado !== 3'd2) begin
      tests_failed++; $display("FAIL b2b_final: w=%b cmd_code=%h cmd_valid=%b estado=%0d expected 1000/5a/1/2",
                               w_vec, cmd_code, cmd_valid, estado);
    end
    tick();
  endtask

  task automatic test_async_reset();
    send_frame(F_W3);
    tick();
    tick();
    tests_run++;
    if (w_vec !== 4'b0100 || estado !== 3'd3) begin
      tests_failed++; $display("FAIL ar_setup: w=%b estado=%0d expected 0100/3", w_vec, estado);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (w_vec !== 4'b0000 || estado !== 3'd0) begin
      tests_failed++; $display("FAIL ar_async: w=%b estado=%0d expected 0000/0", w_vec, estado);
    end
    tests_run++;
    if (err_count !== 8'd0 || cmd_code !== 8'h00) begin
      tests_failed++; $display("FAIL ar_regs: err=%0d cmd_code=%h expected 0/00", err_count, cmd_code);
    end
    #1 reset = 1'b0;
    tick();
    repeat_pulse = 1'b1;
    tick();
    repeat_pulse = 1'b0;
    tick();
    tests_run++;
    if (w_vec !== 4'b0000 || estado !== 3'd0 || cmd_valid !== 1'b0) begin
      tests_failed++; $display("FAIL ar_repeat: w=%b estado=%0d cmd_valid=%b expected 0000/0/0", w_vec, estado, cmd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_w1_timeout();
    test_repeat();
    test_expiry_frame();
    test_errors();
    test_stop();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
